// File: rtl/async_fifo_pkg.sv
// Shared helpers for the asynchronous FIFO: Gray/binary pointer conversion
// and synchroniser depth. Pointer helpers work on a wide container so any
// ADDR_SIZE up to MAX_PTR_W-1 can use them through a zero-extending cast.
package async_fifo_pkg;

  localparam int SYNC_STAGES = 2;
  localparam int MAX_PTR_W   = 16;

  typedef logic [MAX_PTR_W-1:0] wide_ptr_t;

  function automatic wide_ptr_t bin2gray(input wide_ptr_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Leading zeros from the zero-extension leave the low bits unaffected.
  function automatic wide_ptr_t gray2bin(input wide_ptr_t gray);
    wide_ptr_t bin;
    bin[MAX_PTR_W-1] = gray[MAX_PTR_W-1];
    for (int i = MAX_PTR_W-2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/async_rd_fwft_ctrl_if.sv
// Purpose: first-word-fall-through valid/ready stream from the FIFO read side.
// Latency: none (wires only).
// Backpressure: consumer holds m_ready low; source keeps m_valid/m_data stable.
// Ports: m_data (payload), m_valid (source has a word), m_ready (sink accepts).
interface async_rd_fwft_ctrl_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input  m_data, input  m_valid, output m_ready);
endinterface

// File: rtl/gray_ptr_sync.sv
// Purpose: multi-flop synchroniser for a Gray-coded pointer crossing clocks.
// Latency: STAGES clk edges from d_gray to q_gray.
// Backpressure: none; free-running pipeline.
// Ports: clk, rstn (async active-low, clears all stages), d_gray in, q_gray out.
module gray_ptr_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d_gray,
  output logic [WIDTH-1:0] q_gray
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d_gray;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_gray = sync_q[STAGES-1];

endmodule

// File: rtl/async_rd_fwft_ctrl.sv
// Purpose: async FIFO read-side pointer/empty/level logic with a 2-entry FWFT output buffer.
// Latency: ram_rd_en in cycle N -> m_valid in N+2; write pointer change -> empty low after 3 edges.
// Backpressure: m_ready low stops RAM reads once inflight + buffered words reach 2.
// Ports: rd_clk/rd_rstn; wr_addr_gray in (async Gray write pointer); rd_addr, rd_addr_gray,
//        ram_rd_en out and ram_rd_data in (RAM read port); m_if master stream; empty, rd_level status.
module async_rd_fwft_ctrl
  import async_fifo_pkg::*;
#(
  parameter int ADDR_SIZE  = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  rd_clk,
  input  logic                  rd_rstn,
  input  logic [ADDR_SIZE:0]    wr_addr_gray,
  output logic [ADDR_SIZE-1:0]  rd_addr,
  output logic [ADDR_SIZE:0]    rd_addr_gray,
  output logic                  ram_rd_en,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  async_rd_fwft_ctrl_if.master  m_if,
  output logic                  empty,
  output logic [ADDR_SIZE:0]    rd_level
);

  localparam int PTR_W = ADDR_SIZE + 1;

  logic [PTR_W-1:0]      wr_addr_rsyn2;
  logic [PTR_W-1:0]      wr_addr_rbin;
  logic [PTR_W-1:0]      rd_addr_binary;
  logic [PTR_W-1:0]      rd_addr_binary_next;
  logic [PTR_W-1:0]      rd_addr_gray_next;

  logic                  inflight;
  logic [1:0]            buf_cnt;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] skid_q;
  logic                  buf_vld;
  logic                  pop;
  logic [2:0]            occupancy;

  gray_ptr_sync #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_wr_ptr_sync (
    .clk    (rd_clk),
    .rstn   (rd_rstn),
    .d_gray (wr_addr_gray),
    .q_gray (wr_addr_rsyn2)
  );

  assign buf_vld      = (buf_cnt != 2'd0);
  assign pop          = buf_vld && m_if.m_ready;
  assign m_if.m_valid = buf_vld;
  assign m_if.m_data  = head_q;

  // Words owed to the consumer after this cycle's pop: in-flight RAM read
  // plus buffered entries. Keeping this below 2 before issuing guarantees
  // the returning word always finds a free buffer slot.
  always_comb begin
    occupancy           = 3'(inflight) + 3'(buf_cnt) - 3'(pop);
    ram_rd_en           = !empty && (occupancy < 3'd2);
    rd_addr_binary_next = rd_addr_binary + PTR_W'(ram_rd_en);
    rd_addr_gray_next   = PTR_W'(bin2gray(wide_ptr_t'(rd_addr_binary_next)));
    wr_addr_rbin        = PTR_W'(gray2bin(wide_ptr_t'(wr_addr_rsyn2)));
  end

  assign rd_addr = rd_addr_binary[ADDR_SIZE-1:0];

  // Pointer, empty and level registers all look at the post-read pointer so
  // empty rises on the same edge that consumes the last word.
  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      rd_addr_binary <= '0;
      rd_addr_gray   <= '0;
      empty          <= 1'b1;
      rd_level       <= '0;
      inflight       <= 1'b0;
    end else begin
      rd_addr_binary <= rd_addr_binary_next;
      rd_addr_gray   <= rd_addr_gray_next;
      empty          <= (rd_addr_gray_next == wr_addr_rsyn2);
      rd_level       <= wr_addr_rbin - rd_addr_binary_next;
      inflight       <= ram_rd_en;
    end
  end

  // Two-entry in-order buffer: head_q is presented, skid_q holds the next
  // word. RAM data lands at the tail; a pop shifts the skid into the head.
  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      buf_cnt <= 2'd0;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      case ({inflight, pop})
        2'b10: begin
          if (buf_cnt == 2'd0) begin
            head_q <= ram_rd_data;
          end else begin
            skid_q <= ram_rd_data;
          end
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b01: begin
          head_q  <= skid_q;
          buf_cnt <= buf_cnt - 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            head_q <= ram_rd_data;
          end else begin
            head_q <= skid_q;
            skid_q <= ram_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_async_rd_fwft_ctrl.sv
module tb_async_rd_fwft_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          rd_clk       = 1'b0;
  logic          rd_rstn      = 1'b1;
  logic [AW:0]   wr_addr_gray = '0;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   rd_addr_gray;
  logic          ram_rd_en;
  logic [DW-1:0] ram_rd_data  = '0;
  logic          empty;
  logic [AW:0]   rd_level;

  async_rd_fwft_ctrl_if #(.DATA_WIDTH(DW)) m_if ();

  async_rd_fwft_ctrl #(
    .ADDR_SIZE  (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .rd_clk       (rd_clk),
    .rd_rstn      (rd_rstn),
    .wr_addr_gray (wr_addr_gray),
    .rd_addr      (rd_addr),
    .rd_addr_gray (rd_addr_gray),
    .ram_rd_en    (ram_rd_en),
    .ram_rd_data  (ram_rd_data),
    .m_if         (m_if),
    .empty        (empty),
    .rd_level     (rd_level)
  );

  always #5 rd_clk = ~rd_clk;

  // RAM model: one-cycle registered read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge rd_clk) begin
    if (ram_rd_en) ram_rd_data <= mem[rd_addr];
  end

  int            n_asserts = 0;
  int            n_fail    = 0;
  logic [DW-1:0] sb [$];
  int            pop_count = 0;
  int            rd_count  = 0;
  int            cyc       = 0;
  int            first_pop_cyc = 0;
  int            last_pop_cyc  = 0;
  logic          hold_q    = 1'b0;
  logic [DW-1:0] hold_dat  = '0;
  logic [DW-1:0] exp_dat;
  logic [AW:0]   wptr      = '0;
  int            written   = 0;
  logic [DW-1:0] first_word;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: sampled on the falling edge, where m_valid/m_ready show
  // exactly what the next rising edge will act on.
  always @(negedge rd_clk) begin
    if (rd_rstn) begin
      cyc++;
      if (hold_q) begin
        chk("hold_valid", m_if.m_valid, 1);
        chk("hold_data", m_if.m_data, hold_dat);
      end
      chk("outstanding_le2", ((rd_count - pop_count) <= 2), 1);
      chk("rd_level_le16", (rd_level <= 5'd16), 1);
      if (m_if.m_valid && m_if.m_ready) begin
        chk("sb_nonempty_on_pop", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_dat = sb.pop_front();
          chk("data_order", m_if.m_data, exp_dat);
        end
        if (pop_count == 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        pop_count++;
      end
      if (ram_rd_en) rd_count++;
      hold_q   = m_if.m_valid && !m_if.m_ready;
      hold_dat = m_if.m_data;
    end else begin
      hold_q = 1'b0;
    end
  end

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  // Asserts reset 3 time units after a rising edge and checks the outputs
  // 1 unit later, before any further clock edge.
  task automatic do_reset();
    @(posedge rd_clk);
    #3;
    rd_rstn      = 1'b0;
    wr_addr_gray = '0;
    wptr         = '0;
    written      = 0;
    sb.delete();
    pop_count    = 0;
    rd_count     = 0;
    cyc          = 0;
    m_if.m_ready = 1'b0;
    #1;
    chk("rst_m_valid", m_if.m_valid, 0);
    chk("rst_empty", empty, 1);
    chk("rst_rd_level", rd_level, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_rd_addr_gray", rd_addr_gray, 0);
    chk("rst_ram_rd_en", ram_rd_en, 0);
    repeat (2) @(posedge rd_clk);
    #3;
    rd_rstn = 1'b1;
  endtask

  task automatic write_words(input int n);
    for (int i = 0; i < n; i++) begin
      mem[wptr[AW-1:0]] = $urandom;
      sb.push_back(mem[wptr[AW-1:0]]);
      wptr = wptr + 1'b1;
      written++;
    end
    wr_addr_gray = wptr ^ (wptr >> 1);
  endtask

  task automatic wait_pops(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (pop_count < target && k < budget) begin
      tick();
      k++;
    end
    chk(tag, pop_count, target);
  endtask

  initial begin
    // Single word: sync latency, one read, one-cycle m_valid.
    do_reset();
    m_if.m_ready = 1'b1;
    tick();
    write_words(1);
    tick();
    chk("sw_empty_e1", empty, 1);
    tick();
    chk("sw_empty_e2", empty, 1);
    tick();
    chk("sw_empty_e3", empty, 0);
    chk("sw_level_e3", rd_level, 1);
    chk("sw_rd_en_e3", ram_rd_en, 1);
    chk("sw_rd_addr_e3", rd_addr, 0);
    tick();
    chk("sw_empty_e4", empty, 1);
    chk("sw_rd_en_e4", ram_rd_en, 0);
    chk("sw_valid_e4", m_if.m_valid, 0);
    chk("sw_level_e4", rd_level, 0);
    chk("sw_gray_e4", rd_addr_gray, 5'b00001);
    tick();
    chk("sw_valid_e5", m_if.m_valid, 1);
    tick();
    chk("sw_valid_e6", m_if.m_valid, 0);
    chk("sw_pops", pop_count, 1);

    // Burst of a full FIFO: one word per cycle.
    do_reset();
    m_if.m_ready = 1'b1;
    tick();
    write_words(16);
    wait_pops(16, 60, "burst_count");
    chk("burst_back_to_back", last_pop_cyc - first_pop_cyc, 15);
    tick();
    tick();
    chk("burst_empty", empty, 1);
    chk("burst_gray", rd_addr_gray, 5'b11000);
    chk("burst_level", rd_level, 0);
    chk("burst_reads", rd_count, 16);
    chk("burst_valid_end", m_if.m_valid, 0);

    // Backpressure: only two words fetched beyond nothing while stalled.
    do_reset();
    tick();
    write_words(8);
    first_word = sb[0];
    repeat (20) tick();
    chk("bp_reads", rd_count, 2);
    chk("bp_valid", m_if.m_valid, 1);
    chk("bp_head", m_if.m_data, first_word);
    chk("bp_level", rd_level, 6);
    chk("bp_empty", empty, 0);
    chk("bp_rd_en", ram_rd_en, 0);
    m_if.m_ready = 1'b1;
    wait_pops(8, 60, "bp_drain");
    tick();
    tick();
    chk("bp_sb_empty", sb.size(), 0);
    chk("bp_empty_end", empty, 1);
    chk("bp_reads_end", rd_count, 8);

    // Alternating m_ready: pops coincide with RAM returns.
    do_reset();
    tick();
    write_words(10);
    for (int c = 0; c < 80 && pop_count < 10; c++) begin
      m_if.m_ready = c[0];
      tick();
    end
    chk("alt_pops", pop_count, 10);
    chk("alt_sb_empty", sb.size(), 0);

    // Random m_ready across three pointer laps.
    do_reset();
    tick();
    for (int c = 0; c < 4000 && pop_count < 48; c++) begin
      m_if.m_ready = 1'($urandom_range(0, 1));
      if (written < 48 && (written - pop_count) < 16 && $urandom_range(0, 1) == 1)
        write_words(1);
      tick();
    end
    chk("rand_pops", pop_count, 48);
    m_if.m_ready = 1'b1;
    repeat (4) tick();
    chk("rand_sb_empty", sb.size(), 0);
    chk("rand_empty", empty, 1);
    chk("rand_gray", rd_addr_gray, 5'b11000);
    chk("rand_reads", rd_count, 48);

    // Reset in the middle of a stalled transfer discards everything.
    do_reset();
    tick();
    write_words(8);
    repeat (10) tick();
    chk("mid_valid_before", m_if.m_valid, 1);
    do_reset();
    repeat (4) tick();
    chk("mid_valid_after", m_if.m_valid, 0);
    chk("mid_empty_after", empty, 1);
    chk("mid_reads_after", rd_count, 0);
    chk("mid_gray_after", rd_addr_gray, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
